// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic blocks: FSM encoding and default width.
package serial_arith_pkg;

  localparam int unsigned DefaultWidth = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StRun  = S_RUN,
    StDone = S_DONE
  } state_e;

endpackage

// File: rtl/FullAdder.sv
// One-bit full adder cell shared by the serial arithmetic blocks.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] part_q;
  logic [WIDTH-1:0] sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic             cout_q;

  logic fa_sum;
  logic fa_carry;

  FullAdder u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StRun;
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            part_q  <= '0;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          part_q  <= {fa_sum, part_q[WIDTH-1:1]};
          carry_q <= fa_carry;
          if (cnt_q == LastBit) begin
            // Final bit goes straight into the result; the counter stops here.
            sum_q   <= {fa_sum, part_q[WIDTH-1:1]};
            cout_q  <= fa_carry;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder (WIDTH=8) against plain a+b+cin arithmetic.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_cmp;
  int n_bad;
  int cyc;
  int last_done;
  logic [W:0] prev;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one addition and follow it to its done cycle; optionally pulse start mid-run.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input int inject_at);
    logic [W:0] exp;
    int k;
    int busy_n;
    exp = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
    start = 1'b1;
    a = ta;
    b = tb_v;
    cin = tc;
    step();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    k = 0;
    busy_n = 0;
    while (done !== 1'b1 && k < 20) begin
      check("hold", {23'd0, cout, sum}, {23'd0, prev});
      if (busy === 1'b1) busy_n++;
      if (k == inject_at) begin
        start = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
      end
      step();
      start = 1'b0;
      k++;
    end
    check("latency", k, 8);
    check("busy_len", busy_n, 8);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    check("sum", {24'd0, sum}, {24'd0, exp[W-1:0]});
    check("cout", {31'd0, cout}, {31'd0, exp[W]});
    if (last_done >= 0) check("spacing", {31'd0, (cyc - last_done) >= 9}, 32'd1);
    last_done = cyc;
    prev = exp;
  endtask

  initial begin
    int dn;
    n_cmp = 0;
    n_bad = 0;
    last_done = -1;
    prev = '0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;

    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    step();

    run_op(8'h3C, 8'h05, 1'b0, -1);
    check("dir_3c05", {23'd0, cout, sum}, 32'h041);
    step();
    run_op(8'hFF, 8'h01, 1'b0, -1);
    check("dir_ff01", {23'd0, cout, sum}, 32'h100);
    step();
    run_op(8'hFF, 8'hFF, 1'b1, -1);
    check("dir_ffff1", {23'd0, cout, sum}, 32'h1FF);

    // Start during RUN must be ignored; exactly one done and then back to idle.
    step();
    run_op(8'h12, 8'h34, 1'b0, 2);
    check("ign_result", {23'd0, cout, sum}, 32'h046);
    step();
    check("ign_no_done", {31'd0, done}, 32'd0);
    check("ign_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of a run aborts it without a done.
    start = 1'b1;
    a = 8'hA5;
    b = 8'h5A;
    cin = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) dn++;
      step();
    end
    check("abort_no_done", dn, 0);
    prev = '0;
    last_done = -1;
    run_op(8'h7E, 8'h81, 1'b1, -1);

    // Back-to-back: start accepted in the DONE cycle.
    run_op(8'h80, 8'h80, 1'b0, -1);
    check("b2b_8080", {23'd0, cout, sum}, 32'h100);

    for (int n = 0; n < 1000; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step();
      run_op(W'($urandom), W'($urandom), 1'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
